afifo_drain_arbiter: RTL

- Read-clock-domain scheduler that shares one downstream consumer between two asynchronous FIFOs (ch0 = pixel FIFO, ch1 = auxiliary/status FIFO).
- Watches each FIFO's empty flag and head data, grants one channel at a time in round-robin bursts, and issues the FIFO read strobes.
- Presents the granted head word on a valid/ready stream tagged with its source channel.
- Sits between the AFIFO read ports and the pixel packer/SDRAM write path; runs entirely on the FIFOs' read clock.

---
 rtl/afifo_drain_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/afifo_drain_arbiter.sv
// afifo_drain_arbiter: round-robin burst drain of two async-FIFO read ports onto one valid/ready stream.
// Optional per-channel transfer and stall counters are enabled with AFIFO_DRAIN_ARBITER_STATS_EN.
module afifo_drain_arbiter #(
  parameter int Width    = 12,
  parameter int Burst    = 8,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AFIFO_DRAIN_ARBITER_STATS_EN
  input  logic                stats_clr,
  output logic [CntWidth-1:0] cnt0,
  output logic [CntWidth-1:0] cnt1,
  output logic [CntWidth-1:0] stall,
`endif
  input  logic [1:0]          en,
  input  logic                f0_rempty,
  input  logic [Width-1:0]    f0_rd,
  output logic                f0_r,
  input  logic                f1_rempty,
  input  logic [Width-1:0]    f1_rd,
  output logic                f1_r,
  output logic [Width-1:0]    q,
  output logic                q_src,
  output logic                q_valid,
  input  logic                q_ready,
  output logic                busy
);
  localparam int CW = $clog2(Burst + 1);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t        r_state, w_state_nx;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          w_el0, w_el1, w_xfer, w_done;
  assign w_el0  = en[0] & ~f0_rempty;
  assign w_el1  = en[1] & ~f1_rempty;
  assign w_xfer = q_valid & q_ready;
  assign w_done = w_xfer && (r_cnt + 1'b1 == CW'(Burst));
  assign f0_r   = (r_state == GRANT0) & w_xfer;
  assign f1_r   = (r_state == GRANT1) & w_xfer;
  assign busy   = r_state != IDLE;
  always_comb begin
    q          = '0;
    q_src      = 1'b0;
    q_valid    = 1'b0;
    w_state_nx = r_state;
    if (r_state == GRANT0) begin
      q       = f0_rd;
      q_valid = w_el0;
    end else if (r_state == GRANT1) begin
      q       = f1_rd;
      q_src   = 1'b1;
      q_valid = w_el1;
    end
    if (r_state == IDLE)
      w_state_nx = (w_el0 & w_el1) ? (r_last ? GRANT0 : GRANT1) :
                   w_el0 ? GRANT0 : w_el1 ? GRANT1 : IDLE;
    else if (!q_valid || w_done)
      w_state_nx = IDLE;
  end
  // last starts at 1 so ch0 wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && w_state_nx != IDLE) begin
        r_cnt  <= '0;
        r_last <= (w_state_nx == GRANT1);
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`ifdef AFIFO_DRAIN_ARBITER_STATS_EN
  logic [CntWidth-1:0] r_cnt0, r_cnt1, r_stall;
  assign cnt0  = r_cnt0;
  assign cnt1  = r_cnt1;
  assign stall = r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_stall <= '0;
    end else if (stats_clr) begin
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_stall <= '0;
    end else begin
      if (f0_r && ~&r_cnt0) r_cnt0 <= r_cnt0 + 1'b1;
      if (f1_r && ~&r_cnt1) r_cnt1 <= r_cnt1 + 1'b1;
      if (q_valid && !q_ready && ~&r_stall) r_stall <= r_stall + 1'b1;
    end
  end
`endif
endmodule
